// File: rtl/uart_bridge_pkg.sv
// Shared constants, ZLP state encoding and width helper for the UART byte bridge.
// No logic, no latency, no backpressure of its own.
package uart_bridge_pkg;

  localparam int DEF_MAX_PKT  = 64;
  localparam int DEF_ZLP_IDLE = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FULLPKT = 2'd1,
    ZLP     = 2'd2
  } zlp_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with first-word fall-through head; push/pop take effect at the edge.
// Push is ignored when full and pop when empty; a pop on full frees the slot only next cycle.
module sync_byte_fifo
  import uart_bridge_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic          clk_48mhz,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_byte_bridge.sv
// Bridges the app-side uart_we/uart_re byte handshake to CDC bulk valid/ready streams via TX/RX FIFOs.
// Writes land in TX at the accepting edge, reads show on uart_do one cycle later; uart_wait stalls on full/empty.
module uart_byte_bridge
  import uart_bridge_pkg::*;
#(
  parameter  int TX_DEPTH = 16,
  parameter  int RX_DEPTH = 16,
  parameter  int MAX_PKT  = DEF_MAX_PKT,
  parameter  int ZLP_IDLE = DEF_ZLP_IDLE,
  localparam int TX_AW    = clog2(TX_DEPTH)
) (
  input  logic             clk_48mhz,
  input  logic             reset,
  input  logic             uart_we,
  input  logic             uart_re,
  input  logic [7:0]       uart_di,
  output logic [7:0]       uart_do,
  output logic             uart_wait,
  output logic [7:0]       ep_in_data,
  output logic             ep_in_valid,
  output logic             ep_in_last,
  input  logic             ep_in_ready,
  output logic             ep_in_zlp,
  input  logic [7:0]       ep_out_data,
  input  logic             ep_out_valid,
  output logic             ep_out_ready,
  output logic [TX_AW:0]   tx_level
);

  localparam int RX_AW = clog2(RX_DEPTH);
  localparam int PW    = clog2(MAX_PKT);
  localparam int IW    = clog2(ZLP_IDLE + 1);
  localparam logic [PW-1:0]  PKT_LAST   = PW'(MAX_PKT - 1);
  localparam logic [IW-1:0]  IDLE_LIMIT = IW'(ZLP_IDLE);
  localparam logic [TX_AW:0] ONE_ENTRY  = (TX_AW + 1)'(1);

  logic            tx_full;
  logic            tx_empty;
  logic            rx_full;
  logic            rx_empty;
  logic [7:0]      rx_head;
  logic [RX_AW:0]  rx_level;
  logic            unused_rx_level;
  logic            wr_acc;
  logic            rd_acc;
  logic            tx_xfer;
  logic            rx_push;
  logic [PW-1:0]   pkt_cnt;
  logic [IW-1:0]   idle_cnt;
  zlp_state_t      state_q;
  zlp_state_t      state_d;

  // A request seen during reset is held off so it completes only once reset drops.
  assign uart_wait = reset ? (uart_we || uart_re)
                           : ((uart_we && tx_full) || (uart_re && rx_empty));
  assign wr_acc    = uart_we && !uart_wait;
  assign rd_acc    = uart_re && !uart_wait;

  assign ep_in_valid  = !tx_empty;
  assign tx_xfer      = ep_in_valid && ep_in_ready;
  assign ep_out_ready = !rx_full;
  assign rx_push      = ep_out_valid && ep_out_ready;
  assign unused_rx_level = ^rx_level;

  // Close the packet at MAX_PKT, or when the byte on offer is the last one and nothing refills behind it.
  assign ep_in_last = ep_in_valid &&
                      ((pkt_cnt == PKT_LAST) || (tx_level == ONE_ENTRY && !wr_acc));

  sync_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .push      (wr_acc),
    .push_data (uart_di),
    .pop       (tx_xfer),
    .head      (ep_in_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  sync_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .push      (rx_push),
    .push_data (ep_out_data),
    .pop       (rd_acc),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      uart_do <= '0;
      pkt_cnt <= '0;
    end else begin
      if (rd_acc) uart_do <= rx_head;
      if (tx_xfer) pkt_cnt <= ep_in_last ? '0 : pkt_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tx_xfer && ep_in_last && pkt_cnt == PKT_LAST) state_d = FULLPKT;
      FULLPKT: begin
        if (wr_acc || ep_in_valid)     state_d = IDLE;
        else if (idle_cnt == IDLE_LIMIT) state_d = ZLP;
      end
      ZLP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ep_in_zlp = (state_q == ZLP);
  end

  // Idle time only accumulates while parked after a full packet.
  always_ff @(posedge clk_48mhz) begin
    if (reset || state_q != FULLPKT || state_d != FULLPKT) begin
      idle_cnt <= '0;
    end else if (tx_empty) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_byte_bridge.sv
// Self-checking bench for uart_byte_bridge: queue-based reference model checked every cycle,
// a table of cycle vectors for a short write, and directed multi-cycle corner sequences.
module tb_uart_byte_bridge;

  localparam int TXD  = 16;
  localparam int RXD  = 16;
  localparam int MAXP = 64;
  localparam int ZI   = 255;

  logic       clk_48mhz = 1'b0;
  logic       reset;
  logic       uart_we, uart_re;
  logic [7:0] uart_di, uart_do;
  logic       uart_wait;
  logic [7:0] ep_in_data;
  logic       ep_in_valid, ep_in_last, ep_in_ready, ep_in_zlp;
  logic [7:0] ep_out_data;
  logic       ep_out_valid, ep_out_ready;
  logic [4:0] tx_level;

  always #5 clk_48mhz = ~clk_48mhz;

  uart_byte_bridge #(
    .TX_DEPTH(TXD), .RX_DEPTH(RXD), .MAX_PKT(MAXP), .ZLP_IDLE(ZI)
  ) dut (
    .clk_48mhz    (clk_48mhz),
    .reset        (reset),
    .uart_we      (uart_we),
    .uart_re      (uart_re),
    .uart_di      (uart_di),
    .uart_do      (uart_do),
    .uart_wait    (uart_wait),
    .ep_in_data   (ep_in_data),
    .ep_in_valid  (ep_in_valid),
    .ep_in_last   (ep_in_last),
    .ep_in_ready  (ep_in_ready),
    .ep_in_zlp    (ep_in_zlp),
    .ep_out_data  (ep_out_data),
    .ep_out_valid (ep_out_valid),
    .ep_out_ready (ep_out_ready),
    .tx_level     (tx_level)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] exp_do;
  int         pkt_pos;
  bit         armed;
  int         run;
  bit         m_wr, m_rd, m_xfer, m_rxpush, m_last, m_zlp;

  // Observations from the most recent step
  logic s_wait, s_vld, s_zlp;
  int   dut_last = 0;
  int   dut_zlp  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_eval();
    bit exp_wait, exp_vld;
    s_wait = uart_wait;
    s_vld  = ep_in_valid;
    s_zlp  = ep_in_zlp;
    if (reset) begin
      m_wr = 0; m_rd = 0; m_xfer = 0; m_rxpush = 0; m_last = 0; m_zlp = 0;
      return;
    end
    exp_wait = (uart_we && txq.size() == TXD) || (uart_re && rxq.size() == 0);
    m_wr     = uart_we && !exp_wait;
    m_rd     = uart_re && !exp_wait;
    exp_vld  = (txq.size() != 0);
    m_last   = exp_vld && (pkt_pos == MAXP - 1 || (txq.size() == 1 && !m_wr));
    m_zlp    = armed && (run == ZI + 1);
    m_xfer   = exp_vld && ep_in_ready;
    m_rxpush = ep_out_valid && (rxq.size() < RXD);
    chk("uart_wait",    32'(uart_wait),    32'(exp_wait));
    chk("ep_in_valid",  32'(ep_in_valid),  32'(exp_vld));
    chk("ep_in_last",   32'(ep_in_last),   32'(m_last));
    chk("ep_in_zlp",    32'(ep_in_zlp),    32'(m_zlp));
    chk("ep_out_ready", 32'(ep_out_ready), 32'(rxq.size() < RXD));
    chk("tx_level",     32'(tx_level),     32'(txq.size()));
    chk("uart_do",      32'(uart_do),      32'(exp_do));
    if (exp_vld) chk("ep_in_data", 32'(ep_in_data), 32'(txq[0]));
    if (ep_in_valid && ep_in_ready && ep_in_last) dut_last++;
    if (ep_in_zlp) dut_zlp++;
  endtask

  task automatic model_commit();
    if (reset) begin
      txq.delete(); rxq.delete();
      exp_do = 8'h00; pkt_pos = 0; armed = 0; run = 0;
      return;
    end
    if (armed) begin
      if (m_zlp) armed = 0;
      else if (txq.size() != 0 || m_wr) armed = 0;
      else run++;
    end
    if (m_xfer) begin
      void'(txq.pop_front());
      if (m_last) begin
        if (pkt_pos == MAXP - 1) begin
          armed = 1;
          run   = 0;
        end
        pkt_pos = 0;
      end else begin
        pkt_pos = (pkt_pos + 1) % MAXP;
      end
    end
    if (m_wr) txq.push_back(uart_di);
    if (m_rd) exp_do = rxq.pop_front();
    if (m_rxpush) rxq.push_back(ep_out_data);
  endtask

  // Inputs are driven 1ns after the edge; the model samples 2ns after it.
  task automatic step();
    #1;
    model_eval();
    @(posedge clk_48mhz);
    model_commit();
    #1;
  endtask

  typedef struct {
    logic       we;
    logic [7:0] di;
    logic       e_vld;
    logic [7:0] e_dat;
    logic       e_last;
    logic [4:0] e_lvl;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int k, j_empty, j_zlp, last0, zlp0;
    int wp[4] = '{50, 90, 20, 70};
    int rp[4] = '{50, 20, 90, 60};
    int ip[4] = '{80, 30, 90, 50};
    int op[4] = '{50, 90, 20, 70};

    tbl[0] = '{1'b1, 8'h48, 1'b0, 8'h00, 1'b0, 5'd0};
    tbl[1] = '{1'b1, 8'h69, 1'b1, 8'h48, 1'b0, 5'd1};
    tbl[2] = '{1'b1, 8'h0A, 1'b1, 8'h69, 1'b0, 5'd1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 8'h0A, 1'b1, 5'd1};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 5'd0};

    reset = 1; uart_we = 0; uart_re = 0; uart_di = 0;
    ep_in_ready = 0; ep_out_data = 0; ep_out_valid = 0;
    txq.delete(); rxq.delete();
    exp_do = 0; pkt_pos = 0; armed = 0; run = 0;
    @(posedge clk_48mhz); #1;
    step(); step();
    reset = 0;

    // "Hi\n" through a table of per-cycle vectors
    ep_in_ready = 1;
    for (int i = 0; i < 5; i++) begin
      uart_we = tbl[i].we;
      uart_di = tbl[i].di;
      #1;
      chk("tbl_valid", 32'(ep_in_valid), 32'(tbl[i].e_vld));
      chk("tbl_last",  32'(ep_in_last),  32'(tbl[i].e_last));
      chk("tbl_level", 32'(tx_level),    32'(tbl[i].e_lvl));
      if (tbl[i].e_vld) chk("tbl_data", 32'(ep_in_data), 32'(tbl[i].e_dat));
      step();
    end

    // 17 writes into a 16-deep TX FIFO while the IN endpoint is stalled
    ep_in_ready = 0;
    for (int i = 0; i < 16; i++) begin
      uart_we = 1; uart_di = 8'(8'h10 + i);
      step();
    end
    uart_di = 8'h20;
    step();
    chk("stall17_wait", 32'(s_wait), 32'(1));
    step(); step();
    ep_in_ready = 1;
    k = 10;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!s_wait) begin k = i; break; end
    end
    chk("wr17_delay", 32'(k), 32'(1));
    uart_we = 0;
    for (int i = 0; i < 20; i++) step();

    // Read on empty RX stalls until a byte arrives from the OUT endpoint
    uart_re = 1;
    step();
    chk("rd_empty_wait", 32'(s_wait), 32'(1));
    ep_out_valid = 1; ep_out_data = 8'h5A;
    step();
    ep_out_valid = 0;
    step();
    chk("rd_done_wait", 32'(s_wait), 32'(0));
    uart_re = 0;
    for (int i = 0; i < 10; i++) step();
    chk("uart_do_hold", 32'(uart_do), 32'(8'h5A));

    // Full 64-byte packet then idle: ZLP one cycle, ZLP_IDLE+1 cycles after empty
    last0 = dut_last; zlp0 = dut_zlp;
    for (int i = 0; i < MAXP; i++) begin
      uart_we = 1; uart_di = 8'(i);
      step();
    end
    uart_we = 0;
    j_empty = -1; j_zlp = -1;
    for (int j = 0; j < 400; j++) begin
      step();
      if (!s_vld && j_empty < 0) j_empty = j;
      if (s_zlp && j_zlp < 0) j_zlp = j;
    end
    chk("pkt64_lasts", 32'(dut_last - last0), 32'(1));
    chk("zlp_count",   32'(dut_zlp - zlp0),   32'(1));
    chk("zlp_delay",   32'(j_zlp - j_empty),  32'(ZI + 1));

    // Full packet then a late single byte: short packet ends the transfer, no ZLP
    last0 = dut_last; zlp0 = dut_zlp;
    for (int i = 0; i < MAXP; i++) begin
      uart_we = 1; uart_di = 8'(8'hC0 ^ i);
      step();
    end
    uart_we = 0;
    for (int i = 0; i < 20; i++) step();
    uart_we = 1; uart_di = 8'hEE;
    step();
    uart_we = 0;
    for (int i = 0; i < 300; i++) step();
    chk("late_lasts", 32'(dut_last - last0), 32'(2));
    chk("late_nozlp", 32'(dut_zlp - zlp0),   32'(0));

    // Randomised traffic in four phases with differing pressure
    for (int i = 0; i < 3000; i++) begin
      int p;
      p = i / 750;
      uart_we      = ($urandom_range(0, 99) < wp[p]);
      uart_re      = ($urandom_range(0, 99) < rp[p]);
      uart_di      = 8'($urandom);
      ep_in_ready  = ($urandom_range(0, 99) < ip[p]);
      ep_out_valid = ($urandom_range(0, 99) < op[p]);
      ep_out_data  = 8'($urandom);
      step();
    end
    uart_we = 0; uart_re = 0; ep_out_valid = 0;

    // Fill RX, hold some TX, then a one-cycle reset mid-stream
    uart_re = 1;
    for (int i = 0; i < 40; i++) step();
    uart_re = 0; ep_in_ready = 0; ep_out_valid = 0;
    uart_we = 1; uart_di = 8'h33;
    step(); step(); step();
    uart_we = 0;
    for (int i = 0; i < 18; i++) begin
      ep_out_valid = 1; ep_out_data = 8'($urandom);
      step();
    end
    chk("rx_full_rdy", 32'(ep_out_ready), 32'(0));
    reset = 1;
    step();
    reset = 0; ep_out_valid = 0; uart_re = 1;
    #1;
    chk("rst_out_ready", 32'(ep_out_ready), 32'(1));
    chk("rst_uart_do",   32'(uart_do),      32'(0));
    chk("rst_tx_level",  32'(tx_level),     32'(0));
    chk("rst_re_wait",   32'(uart_wait),    32'(1));
    step();
    uart_re = 0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
